// File: rtl/fifo_sample_player.sv
// fifo_sample_player: drains 32-bit words from the sample FIFO and plays them
// byte by byte (LSB first) into the DAC amplitude input at a programmable rate.
//
// state | meaning
// IDLE  | not playing; amplitude parked at IDLE_LEVEL
// FETCH | read strobe for the first word of a play run
// WAIT  | first word returns from the FIFO and lands in the word buffer
// PLAY  | emitting samples on each tick, prefetching the next word
module fifo_sample_player #(
  parameter int unsigned DIV_W      = 32,
  parameter int unsigned CNT_W      = 32,
  parameter logic [11:0] IDLE_LEVEL = 12'h080
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_dout,
  output logic             fifo_rd_en,
  output logic [11:0]      ampl,
  output logic             sample_strobe,
  output logic             playing,
  output logic             underrun,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    PLAY  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic             word_vld_q, word_vld_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      pf_q, pf_d;
  logic             pf_vld_q, pf_vld_d;
  logic             rd_pend_q, rd_pend_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [11:0]      ampl_q, ampl_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             rd_en_c;
  logic             pf_now_vld;
  logic [31:0]      pf_now;
  logic [DIV_W-1:0] reload;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // A prefetch read returning this cycle counts as available for this tick.
  assign pf_now_vld = pf_vld_q | rd_pend_q;
  assign pf_now     = rd_pend_q ? fifo_dout : pf_q;
  assign reload     = (rate_div <= DIV_W'(1)) ? '0 : rate_div - DIV_W'(1);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    word_vld_d = word_vld_q;
    idx_d      = idx_q;
    pf_d       = pf_q;
    pf_vld_d   = pf_vld_q;
    rd_pend_d  = 1'b0;
    tick_d     = tick_q;
    ampl_d     = ampl_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    count_d    = count_q;
    rd_en_c    = 1'b0;

    if (!enable) begin
      // Any outstanding read is simply forgotten; its data is never captured.
      state_d    = IDLE;
      word_vld_d = 1'b0;
      pf_vld_d   = 1'b0;
      idx_d      = '0;
      tick_d     = '0;
      ampl_d     = IDLE_LEVEL;
      underrun_d = 1'b0;
      count_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_d = FETCH;
        end
        FETCH: begin
          if (!fifo_empty) begin
            rd_en_c = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          word_d     = fifo_dout;
          word_vld_d = 1'b1;
          idx_d      = '0;
          tick_d     = '0;
          state_d    = PLAY;
        end
        PLAY: begin
          if (rd_pend_q) begin
            pf_d     = fifo_dout;
            pf_vld_d = 1'b1;
          end
          if (!pf_vld_q && !rd_pend_q && !fifo_empty) begin
            rd_en_c   = 1'b1;
            rd_pend_d = 1'b1;
          end
          if (tick_q == '0) begin
            tick_d = reload;
            if (word_vld_q) begin
              ampl_d   = {4'b0, pick_byte(word_q, idx_q)};
              strobe_d = 1'b1;
              count_d  = count_q + CNT_W'(1);
              idx_d    = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                if (pf_now_vld) begin
                  word_d   = pf_now;
                  pf_vld_d = 1'b0;
                end else begin
                  word_vld_d = 1'b0;
                end
              end
            end else if (pf_now_vld) begin
              // Recovering from an underrun: play byte 0 of the fresh word now.
              ampl_d     = {4'b0, pf_now[7:0]};
              strobe_d   = 1'b1;
              count_d    = count_q + CNT_W'(1);
              word_d     = pf_now;
              word_vld_d = 1'b1;
              idx_d      = 2'd1;
              pf_vld_d   = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            tick_d = tick_q - DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      idx_q      <= '0;
      pf_q       <= '0;
      pf_vld_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      tick_q     <= '0;
      ampl_q     <= IDLE_LEVEL;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      idx_q      <= idx_d;
      pf_q       <= pf_d;
      pf_vld_q   <= pf_vld_d;
      rd_pend_q  <= rd_pend_d;
      tick_q     <= tick_d;
      ampl_q     <= ampl_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
    end
  end

  assign fifo_rd_en    = rd_en_c;
  assign ampl          = ampl_q;
  assign sample_strobe = strobe_q;
  assign playing       = (state_q != IDLE);
  assign underrun      = underrun_q;
  assign sample_count  = count_q;

endmodule

// File: tb/tb_fifo_sample_player.sv
// Scoreboard bench for fifo_sample_player: directed play runs with hand-computed
// samples queued up front, checked by a monitor on every sample_strobe.
module tb_fifo_sample_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] rate_div;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic [11:0] ampl;
  logic        sample_strobe;
  logic        playing;
  logic        underrun;
  logic [31:0] sample_count;

  fifo_sample_player dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .rate_div      (rate_div),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .ampl          (ampl),
    .sample_strobe (sample_strobe),
    .playing       (playing),
    .underrun      (underrun),
    .sample_count  (sample_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ampl;
    logic [31:0] cnt;
    logic        ur;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          strobe_times[$];
  logic [31:0] fq[$];
  int          cyc = 0;
  int          rd_count = 0;
  int          errors = 0;
  int          checks = 0;
  logic        push_v = 1'b0;
  logic [31:0] push_w = '0;
  int          rd_base;
  int          ts0;
  int          n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic exp_s(input logic [11:0] a, input int c, input logic u);
    sb.push_back('{ampl: a, cnt: 32'(c), ur: u});
  endtask

  task automatic push_word(input logic [31:0] w);
    push_w = w;
    push_v = 1'b1;
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  function automatic int gap(input int k);
    if (k < 1 || k >= strobe_times.size()) return -1;
    return strobe_times[k] - strobe_times[k-1];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural standard-mode FIFO: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      rd_count++;
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
    end
    if (push_v) fq.push_back(push_w);
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (reset_n && sample_strobe) begin
      strobe_times.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: ampl=%h count=%0d (cycle %0d)", ampl, sample_count, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("sample_ampl", {20'd0, ampl}, {20'd0, mon_e.ampl});
        check("sample_count", sample_count, mon_e.cnt);
        check("sample_underrun", {31'd0, underrun}, {31'd0, mon_e.ur});
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    rate_div = 32'd4;
    repeat (3) @(negedge clk);
    check("rst_ampl", {20'd0, ampl}, 32'h080);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_count", sample_count, 32'd0);
    reset_n = 1'b1;

    // idle with data present but enable low
    push_word(32'h4433_2211);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("idle_ampl", {20'd0, ampl}, 32'h080);
    end

    // basic play, rate 4
    rd_base = rd_count;
    ts0 = strobe_times.size();
    exp_s(12'h011, 1, 1'b0);
    exp_s(12'h022, 2, 1'b0);
    exp_s(12'h033, 3, 1'b0);
    exp_s(12'h044, 4, 1'b0);
    enable = 1'b1;
    drain("basic", 40);
    for (int k = 1; k < 4; k++) check("basic_period", 32'(gap(ts0 + k)), 32'd4);
    check("basic_rd_count", 32'(rd_count - rd_base), 32'd1);
    check("basic_count", sample_count, 32'd4);
    enable = 1'b0;
    @(negedge clk);
    check("drop_ampl", {20'd0, ampl}, 32'h080);
    check("drop_count", sample_count, 32'd0);
    check("drop_underrun", {31'd0, underrun}, 32'd0);
    check("drop_playing", {31'd0, playing}, 32'd0);

    // gapless, rate 1, three words
    rate_div = 32'd1;
    push_word(32'h0403_0201);
    push_word(32'h0807_0605);
    push_word(32'h0C0B_0A09);
    ts0 = strobe_times.size();
    for (int i = 1; i <= 12; i++) exp_s(12'(i), i, 1'b0);
    enable = 1'b1;
    drain("gapless", 60);
    for (int k = 1; k < 12; k++) check("gapless_period", 32'(gap(ts0 + k)), 32'd1);
    enable = 1'b0;
    @(negedge clk);

    // underrun, rate 2, then resume
    rate_div = 32'd2;
    push_word(32'hDDCC_BBAA);
    exp_s(12'h0AA, 1, 1'b0);
    exp_s(12'h0BB, 2, 1'b0);
    exp_s(12'h0CC, 3, 1'b0);
    exp_s(12'h0DD, 4, 1'b0);
    enable = 1'b1;
    drain("under_first", 40);
    repeat (6) @(negedge clk);
    check("under_flag", {31'd0, underrun}, 32'd1);
    check("under_hold_ampl", {20'd0, ampl}, 32'h0DD);
    check("under_hold_count", sample_count, 32'd4);
    check("under_playing", {31'd0, playing}, 32'd1);
    exp_s(12'h021, 5, 1'b1);
    exp_s(12'h043, 6, 1'b1);
    exp_s(12'h065, 7, 1'b1);
    exp_s(12'h087, 8, 1'b1);
    ts0 = strobe_times.size();
    push_word(32'h8765_4321);
    drain("under_resume", 40);
    check("under_sticky", {31'd0, underrun}, 32'd1);
    for (int k = 1; k < 4; k++) check("resume_period", 32'(gap(ts0 + k)), 32'd2);
    enable = 1'b0;
    @(negedge clk);

    // rate change 8 -> 3 in the middle of the first period
    rate_div = 32'd8;
    push_word(32'h5544_3322);
    exp_s(12'h022, 1, 1'b0);
    exp_s(12'h033, 2, 1'b0);
    exp_s(12'h044, 3, 1'b0);
    exp_s(12'h055, 4, 1'b0);
    ts0 = strobe_times.size();
    enable = 1'b1;
    n = 0;
    while (strobe_times.size() <= ts0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rate_first_strobe", 32'(strobe_times.size() - ts0), 32'd1);
    repeat (2) @(negedge clk);
    rate_div = 32'd3;
    drain("rate", 60);
    check("rate_old_period", 32'(gap(ts0 + 1)), 32'd8);
    check("rate_new_period1", 32'(gap(ts0 + 2)), 32'd3);
    check("rate_new_period2", 32'(gap(ts0 + 3)), 32'd3);
    enable = 1'b0;
    @(negedge clk);

    // enable drop while the first word is in flight
    rate_div = 32'd1;
    push_word(32'hA5A5_A5A5);
    rd_base = rd_count;
    enable = 1'b1;
    @(negedge clk);
    check("fetch_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    check("wait_playing", {31'd0, playing}, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("wdrop_playing", {31'd0, playing}, 32'd0);
    check("wdrop_ampl", {20'd0, ampl}, 32'h080);
    check("wdrop_count", sample_count, 32'd0);
    check("wdrop_strobe", {31'd0, sample_strobe}, 32'd0);
    check("wdrop_rd_count", 32'(rd_count - rd_base), 32'd1);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("empty_idle_playing", {31'd0, playing}, 32'd0);
    check("empty_idle_underrun", {31'd0, underrun}, 32'd0);
    check("no_replay_rd_count", 32'(rd_count - rd_base), 32'd1);
    enable = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of PLAY
    rate_div = 32'd4;
    push_word(32'h0000_00F0);
    exp_s(12'h0F0, 1, 1'b0);
    enable = 1'b1;
    drain("prereset", 40);
    repeat (2) @(negedge clk);
    check("prereset_count", sample_count, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_ampl", {20'd0, ampl}, 32'h080);
    check("async_count", sample_count, 32'd0);
    check("async_playing", {31'd0, playing}, 32'd0);
    check("async_strobe", {31'd0, sample_strobe}, 32'd0);
    check("async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_ampl", {20'd0, ampl}, 32'h080);
      check("post_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
